// File: rtl/divider_seq_sched.sv
// divider_seq_sched: shares one sequential divider core between two
// requesters with round-robin grant, divide-by-zero bypass and timeout.
module divider_seq_sched #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] dividend0,
   input  logic [WIDTH-1:0] divisor0,
   input  logic [WIDTH-1:0] dividend1,
   input  logic [WIDTH-1:0] divisor1,
   output logic [1:0]       ack,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             err,
   output logic             busy,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t           state, state_nx;
   logic             id, id_nx;
   logic             ptr, ptr_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] q_nx, r_nx;
   logic             err_nx;
   logic [WIDTH-1:0] opa_nx, opb_nx;
   logic             gnt;
   logic [WIDTH-1:0] sel_a, sel_b;

   // ptr holds the last served id; reset to R1 so R0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         id           <= 1'b0;
         ptr          <= 1'b1;
         cnt          <= '0;
         quotient     <= '0;
         remainder    <= '0;
         err          <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         state        <= state_nx;
         id           <= id_nx;
         ptr          <= ptr_nx;
         cnt          <= cnt_nx;
         quotient     <= q_nx;
         remainder    <= r_nx;
         err          <= err_nx;
         div_dividend <= opa_nx;
         div_divisor  <= opb_nx;
      end
   end

   always_comb begin
      state_nx = state;
      id_nx    = id;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      q_nx     = quotient;
      r_nx     = remainder;
      err_nx   = err;
      opa_nx   = div_dividend;
      opb_nx   = div_divisor;
      gnt      = 1'b0;
      sel_a    = '0;
      sel_b    = '0;
      unique case (state)
         IDLE: begin
            if (req != 2'b00) begin
               if (req == 2'b11) gnt = ~ptr;
               else              gnt = req[1];
               sel_a  = gnt ? dividend1 : dividend0;
               sel_b  = gnt ? divisor1  : divisor0;
               id_nx  = gnt;
               opa_nx = sel_a;
               opb_nx = sel_b;
               if (sel_b == '0) begin
                  state_nx = RESP;
                  err_nx   = 1'b1;
                  q_nx     = '1;
                  r_nx     = sel_a;
               end else begin
                  state_nx = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            // a done arriving on the last allowed cycle still counts
            if (div_done) begin
               state_nx = RESP;
               err_nx   = 1'b0;
               q_nx     = div_quotient;
               r_nx     = div_remainder;
            end else if (cnt == CNT_LAST) begin
               state_nx = RESP;
               err_nx   = 1'b1;
               q_nx     = '0;
               r_nx     = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RESP: begin
            ptr_nx   = id;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ack       = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
   assign div_start = (state == ISSUE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_divider_seq_sched.sv
// tb_divider_seq_sched: scoreboard bench for the divider scheduler,
// with a behavioural divider core of programmable latency.
module tb_divider_seq_sched;

   localparam int W  = 16;
   localparam int TO = 64;

   typedef struct packed {
      logic [1:0]   ack;
      logic         err;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req;
   logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
   logic [1:0]   ack;
   logic [W-1:0] quotient, remainder;
   logic         err, busy, div_start;
   logic [W-1:0] div_dividend, div_divisor;
   logic         div_done;
   logic [W-1:0] div_quotient, div_remainder;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;
   int   starts    = 0;
   int   last_start = 0;
   exp_t sb[$];

   int   core_lat = 17;
   bit   core_en  = 1'b1;
   int   ccnt;
   logic core_done;
   logic done_force;

   divider_seq_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .dividend0(dividend0), .divisor0(divisor0),
      .dividend1(dividend1), .divisor1(divisor1),
      .ack(ack), .quotient(quotient), .remainder(remainder),
      .err(err), .busy(busy), .div_start(div_start),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient),
      .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (div_start) begin
         starts     <= starts + 1;
         last_start <= cyc;
      end
   end

   // core raises done core_lat cycles after the cycle carrying div_start
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ccnt      <= 0;
         core_done <= 1'b0;
      end else if (div_start && core_en) begin
         ccnt      <= core_lat - 1;
         core_done <= 1'b0;
      end else if (ccnt != 0) begin
         ccnt      <= ccnt - 1;
         core_done <= (ccnt == 1);
      end else begin
         core_done <= 1'b0;
      end
   end

   assign div_done      = core_done | done_force;
   assign div_quotient  = (div_divisor != 0) ? div_dividend / div_divisor : '1;
   assign div_remainder = (div_divisor != 0) ? div_dividend % div_divisor : '0;

   task automatic wait_ack(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [6*W+5:0] got;
      rst = 1'b0; req = 2'b00; done_force = 1'b0;
      dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
      #12;
      got = {ack, div_start, busy, err, quotient, remainder,
             div_dividend, div_divisor, 32'h0};
      total_cnt++;
      if (got !== '0)
         $display("FAIL reset_outputs got=%h want=0", got);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0)
         $display("FAIL idle_busy got=%b want=0", busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      int t0; bit seen; exp_t e;
      @(negedge clk);
      dividend0 = 16'd100; divisor0 = 16'd7; req = 2'b01;
      t0 = cyc;
      sb.push_back('{2'b01, 1'b0, 16'd14, 16'd2});
      wait_ack(40, seen);
      req = 2'b00;
      total_cnt++;
      if (!seen || cyc - t0 + 1 != 20)
         $display("FAIL single_latency got=%0d want=20", seen ? cyc - t0 + 1 : -1);
      else pass_cnt++;
      total_cnt++;
      if (last_start - t0 != 1)
         $display("FAIL single_start got=%0d want=1", last_start - t0);
      else pass_cnt++;
      pop_exp(e);
      total_cnt++;
      if ({ack, err, quotient, remainder} !== e)
         $display("FAIL single_result got=%h want=%h", {ack, err, quotient, remainder}, e);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({ack, quotient} !== {2'b00, 16'd14})
         $display("FAIL single_hold got=%h want=%h", {ack, quotient}, {2'b00, 16'd14});
      else pass_cnt++;
   endtask

   task automatic test_tie();
      bit seen; exp_t e;
      do_reset();
      @(negedge clk);
      dividend0 = 16'd50; divisor0 = 16'd5;
      dividend1 = 16'd9;  divisor1 = 16'd4;
      req = 2'b11;
      for (int k = 0; k < 2; k++) begin
         sb.push_back('{2'b01, 1'b0, 16'd10, 16'd0});
         sb.push_back('{2'b10, 1'b0, 16'd2,  16'd1});
      end
      for (int k = 0; k < 4; k++) begin
         wait_ack(40, seen);
         if (k == 3) req = 2'b00;
         pop_exp(e);
         total_cnt++;
         if (!seen || {ack, err, quotient, remainder} !== e)
            $display("FAIL tie_%0d got=%h want=%h", k, {ack, err, quotient, remainder}, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_div0();
      int t0, s0; bit seen; exp_t e;
      @(negedge clk);
      dividend1 = 16'h1234; divisor1 = 16'h0; req = 2'b10;
      t0 = cyc; s0 = starts;
      sb.push_back('{2'b10, 1'b1, 16'hFFFF, 16'h1234});
      wait_ack(10, seen);
      req = 2'b00;
      total_cnt++;
      if (!seen || cyc - t0 + 1 != 2)
         $display("FAIL div0_latency got=%0d want=2", seen ? cyc - t0 + 1 : -1);
      else pass_cnt++;
      pop_exp(e);
      total_cnt++;
      if ({ack, err, quotient, remainder} !== e)
         $display("FAIL div0_result got=%h want=%h", {ack, err, quotient, remainder}, e);
      else pass_cnt++;
      total_cnt++;
      if (starts != s0)
         $display("FAIL div0_nostart got=%0d want=%0d", starts, s0);
      else pass_cnt++;
   endtask

   task automatic run_one(input string name, input logic who,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t want, input int lat);
      int t0; bit seen; exp_t e;
      @(negedge clk);
      if (who) begin dividend1 = a; divisor1 = b; req = 2'b10; end
      else     begin dividend0 = a; divisor0 = b; req = 2'b01; end
      t0 = cyc;
      sb.push_back(want);
      wait_ack(lat + 20, seen);
      req = 2'b00;
      pop_exp(e);
      total_cnt++;
      if (!seen || cyc - t0 + 1 != lat || {ack, err, quotient, remainder} !== e)
         $display("FAIL %s got=%h lat=%0d want=%h lat=%0d", name,
                  {ack, err, quotient, remainder}, seen ? cyc - t0 + 1 : -1, e, lat);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      core_en = 1'b0;
      run_one("timeout", 1'b0, 16'd1000, 16'd10, '{2'b01, 1'b1, 16'd0, 16'd0}, 3 + TO);
      core_en = 1'b1;
      run_one("after_timeout", 1'b1, 16'd77, 16'd7, '{2'b10, 1'b0, 16'd11, 16'd0}, 20);
   endtask

   task automatic test_done_edge();
      core_lat = TO;
      run_one("done_last_cycle", 1'b0, 16'd500, 16'd9, '{2'b01, 1'b0, 16'd55, 16'd5}, 3 + TO);
      core_lat = TO + 1;
      run_one("done_too_late", 1'b0, 16'd500, 16'd9, '{2'b01, 1'b1, 16'd0, 16'd0}, 3 + TO);
      @(negedge clk);
      total_cnt++;
      if ({ack, busy} !== 3'b000)
         $display("FAIL late_done_ignored got=%b want=000", {ack, busy});
      else pass_cnt++;
      core_lat = 17;
   endtask

   task automatic test_reset_mid();
      int acks;
      @(negedge clk);
      dividend1 = 16'd300; divisor1 = 16'd4; req = 2'b10;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({ack, div_start, busy, err, quotient, remainder, div_dividend, div_divisor} !== '0)
         $display("FAIL reset_mid got=%h want=0",
                  {ack, div_start, busy, err, quotient, remainder, div_dividend, div_divisor});
      else pass_cnt++;
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      acks = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         done_force = (i == 2);
         if (ack != 2'b00 || busy) acks++;
      end
      done_force = 1'b0;
      total_cnt++;
      if (acks != 0)
         $display("FAIL reset_no_ack got=%0d want=0", acks);
      else pass_cnt++;
      run_one("after_reset", 1'b1, 16'd300, 16'd4, '{2'b10, 1'b0, 16'd75, 16'd0}, 20);
   endtask

   task automatic test_operand_change();
      int t0; bit seen; exp_t e;
      @(negedge clk);
      dividend0 = 16'd100; divisor0 = 16'd7; req = 2'b01;
      t0 = cyc;
      sb.push_back('{2'b01, 1'b0, 16'd14, 16'd2});
      repeat (4) @(negedge clk);
      req = 2'b00; dividend0 = 16'd200; divisor0 = 16'd3;
      @(negedge clk);
      total_cnt++;
      if ({div_dividend, div_divisor} !== {16'd100, 16'd7})
         $display("FAIL operand_stable got=%h want=%h", {div_dividend, div_divisor},
                  {16'd100, 16'd7});
      else pass_cnt++;
      wait_ack(40, seen);
      pop_exp(e);
      total_cnt++;
      if (!seen || cyc - t0 + 1 != 20 || {ack, err, quotient, remainder} !== e)
         $display("FAIL operand_change got=%h want=%h", {ack, err, quotient, remainder}, e);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_div0();
      test_timeout();
      test_done_edge();
      test_reset_mid();
      test_operand_change();
      total_cnt++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
